tlut_mm_engine: RTL and testbench

TLUT_MM_ENGINE -- requirements
Module: tlut_mm_engine

---
 rtl/tlut_mm_engine_pkg.sv | 18 +
 rtl/tlut_mm_engine_if.sv | 33 +++
 rtl/tlut_adder_tree.sv | 16 +
 rtl/tlut_mm_engine.sv | 125 ++++++++++++
 tb/tb_tlut_mm_engine.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/tlut_mm_engine_pkg.sv
// rtl/tlut_mm_engine_pkg.sv - shared dimensions, widths and FSM state type for the time-LUT matmul engine
package tlut_mm_engine_pkg;

    localparam int DEF_DIM_ROW1     = 3;
    localparam int DEF_DIM_COL1     = 3;
    localparam int DEF_DIM_ROW2     = 3;
    localparam int DEF_DIM_COL2     = 3;
    localparam int DEF_INPUT_WIDTH  = 4;
    localparam int DEF_WEIGHT_WIDTH = 4;
    localparam int DEF_ACC_WIDTH    = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tlut_mm_engine_if.sv
// rtl/tlut_mm_engine_if.sv - tile handshake, operand and result bundle of the matmul engine
interface tlut_mm_engine_if
    import tlut_mm_engine_pkg::*;
#(
    parameter int DIM_ROW1     = DEF_DIM_ROW1,
    parameter int DIM_COL1     = DEF_DIM_COL1,
    parameter int DIM_ROW2     = DEF_DIM_ROW2,
    parameter int DIM_COL2     = DEF_DIM_COL2,
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH
);
    logic                                             enable;
    logic                                             in_valid;
    logic                                             in_ready;
    logic                                             acc_clear;
    logic [DIM_ROW1*DIM_COL1-1:0][INPUT_WIDTH-1:0]    input_bin;
    logic [DIM_ROW2*DIM_COL2-1:0][WEIGHT_WIDTH-1:0]   weight_bin;
    logic                                             out_valid;
    logic                                             out_ready;
    logic [DIM_ROW1*DIM_COL2-1:0][ACC_WIDTH-1:0]      accumulated_mult;
    logic                                             busy;

    modport master (
        output enable, in_valid, acc_clear, input_bin, weight_bin, out_ready,
        input  in_ready, out_valid, accumulated_mult, busy
    );

    modport slave (
        input  enable, in_valid, acc_clear, input_bin, weight_bin, out_ready,
        output in_ready, out_valid, accumulated_mult, busy
    );
endinterface

// File: rtl/tlut_adder_tree.sv
// rtl/tlut_adder_tree.sv - combinational sum of the gated weights feeding one output element
module tlut_adder_tree #(
    parameter int N_IN      = 3,
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 13
) (
    input  logic [N_IN-1:0][IN_WIDTH-1:0] gated_w,
    output logic [OUT_WIDTH-1:0]          sum
);
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            sum = sum + OUT_WIDTH'(gated_w[k]);
        end
    end
endmodule

// File: rtl/tlut_mm_engine.sv
// rtl/tlut_mm_engine.sv - unary-time matrix multiply: one threshold step of A per enabled cycle
module tlut_mm_engine
    import tlut_mm_engine_pkg::*;
#(
    parameter int DIM_ROW1     = DEF_DIM_ROW1,
    parameter int DIM_COL1     = DEF_DIM_COL1,
    parameter int DIM_ROW2     = DEF_DIM_ROW2,
    parameter int DIM_COL2     = DEF_DIM_COL2,
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH
) (
    input logic             clk,
    input logic             rst_n,
    tlut_mm_engine_if.slave bus
);
    localparam int N_A = DIM_ROW1 * DIM_COL1;
    localparam int N_W = DIM_ROW2 * DIM_COL2;
    localparam int N_O = DIM_ROW1 * DIM_COL2;

    if (DIM_COL1 != DIM_ROW2) begin : g_dim_check
        $error("tlut_mm_engine: DIM_COL1 must equal DIM_ROW2");
    end

    state_t                                  state;
    logic [INPUT_WIDTH-1:0]                  t;
    logic [INPUT_WIDTH-1:0]                  m;
    logic [INPUT_WIDTH-1:0]                  a_max;
    logic [N_A-1:0][INPUT_WIDTH-1:0]         a_q;
    logic [N_W-1:0][WEIGHT_WIDTH-1:0]        w_q;
    logic [N_O-1:0][ACC_WIDTH-1:0]           acc;
    logic [N_O-1:0][ACC_WIDTH-1:0]           sums;
    logic                                    in_ready_q;
    logic                                    out_valid_q;
    logic                                    busy_q;
    logic                                    last_step;

    always_comb begin
        a_max = '0;
        for (int e = 0; e < N_A; e++) begin
            if (bus.input_bin[e] > a_max) a_max = bus.input_bin[e];
        end
    end

    // A[i][k] > t turns element (i,k) into a unary pulse train of length A[i][k]
    for (genvar i = 0; i < DIM_ROW1; i++) begin : g_row
        for (genvar j = 0; j < DIM_COL2; j++) begin : g_col
            logic [DIM_COL1-1:0][WEIGHT_WIDTH-1:0] gated;
            for (genvar k = 0; k < DIM_COL1; k++) begin : g_gate
                assign gated[k] = (a_q[i*DIM_COL1+k] > t) ? w_q[k*DIM_COL2+j] : '0;
            end
            tlut_adder_tree #(
                .N_IN      (DIM_COL1),
                .IN_WIDTH  (WEIGHT_WIDTH),
                .OUT_WIDTH (ACC_WIDTH)
            ) u_tree (
                .gated_w (gated),
                .sum     (sums[i*DIM_COL2+j])
            );
        end
    end

    // M == 0 still takes one RUN cycle; its gated sums are all zero
    assign last_step = (m == '0) || (t == m - INPUT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            t           <= '0;
            m           <= '0;
            a_q         <= '0;
            w_q         <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.input_bin;
                        w_q        <= bus.weight_bin;
                        m          <= a_max;
                        t          <= '0;
                        if (bus.acc_clear) acc <= '0;
                        state      <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.enable) begin
                        for (int o = 0; o < N_O; o++) begin
                            acc[o] <= acc[o] + sums[o];
                        end
                        t <= t + INPUT_WIDTH'(1);
                        if (last_step) begin
                            state       <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.busy             = busy_q;
    assign bus.accumulated_mult = acc;
endmodule

// File: tb/tb_tlut_mm_engine.sv
// tb/tb_tlut_mm_engine.sv - directed self-checking bench for tlut_mm_engine
module tb_tlut_mm_engine;

    typedef logic [8:0][3:0]  in_t;
    typedef logic [8:0][12:0] res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    tlut_mm_engine_if #(
        .DIM_ROW1(3), .DIM_COL1(3), .DIM_ROW2(3), .DIM_COL2(3),
        .INPUT_WIDTH(4), .WEIGHT_WIDTH(4), .ACC_WIDTH(13)
    ) bus ();

    tlut_mm_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic in_t fill_in(input int v);
        in_t r;
        for (int e = 0; e < 9; e++) r[e] = 4'(v);
        return r;
    endfunction

    function automatic res_t fill_res(input int v);
        res_t r;
        for (int e = 0; e < 9; e++) r[e] = 13'(v);
        return r;
    endfunction

    // Called at a falling edge; returns the number of RUN-state cycles seen before out_valid.
    task automatic run_tile(input string tag, input in_t a, input in_t w, input logic clr,
                            input int stall_at, input int stall_len, output int cycles);
        int guard;
        guard  = 0;
        cycles = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " in_ready"}, 128'(bus.in_ready), 128'(1));
        bus.input_bin  = a;
        bus.weight_bin = w;
        bus.acc_clear  = clr;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, " busy/in_ready in RUN"}, 128'({bus.busy, bus.in_ready}), 128'(2'b10));
        while (!bus.out_valid && cycles < 200) begin
            cycles++;
            bus.enable = !(stall_len > 0 && cycles >= stall_at && cycles < stall_at + stall_len);
            @(negedge clk);
        end
        bus.enable = 1'b1;
        check({tag, " out_valid"}, 128'(bus.out_valid), 128'(1));
    endtask

    task automatic consume(input string tag, input int hold, input res_t exp);
        check({tag, " result"}, 128'(bus.accumulated_mult), 128'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " held"}, 128'({bus.out_valid, bus.accumulated_mult}), 128'({1'b1, exp}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " back to idle"}, 128'({bus.out_valid, bus.busy, bus.in_ready}), 128'(3'b001));
    endtask

    initial begin
        in_t  idx;
        res_t exp_idx;
        int   cyc;

        idx     = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        exp_idx = {13'd111, 13'd90, 13'd69, 13'd66, 13'd54, 13'd42, 13'd21, 13'd18, 13'd15};

        bus.enable     = 1'b1;
        bus.in_valid   = 1'b0;
        bus.acc_clear  = 1'b0;
        bus.out_ready  = 1'b0;
        bus.input_bin  = '0;
        bus.weight_bin = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset flags", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(3'b100));
        check("reset acc", 128'(bus.accumulated_mult), 128'(0));

        run_tile("idx", idx, idx, 1'b1, 0, 0, cyc);
        check("idx run cycles", 128'(cyc), 128'(8));
        consume("idx", 0, exp_idx);

        run_tile("fours", fill_in(4), fill_in(1), 1'b1, 0, 0, cyc);
        check("fours run cycles", 128'(cyc), 128'(4));
        consume("fours", 0, fill_res(12));

        run_tile("fours acc", fill_in(4), fill_in(1), 1'b0, 0, 0, cyc);
        check("fours acc run cycles", 128'(cyc), 128'(4));
        consume("fours acc", 0, fill_res(24));

        run_tile("zero keep", fill_in(0), fill_in(7), 1'b0, 0, 0, cyc);
        check("zero keep run cycles", 128'(cyc), 128'(1));
        consume("zero keep", 0, fill_res(24));

        run_tile("zero clr", fill_in(0), fill_in(7), 1'b1, 0, 0, cyc);
        check("zero clr run cycles", 128'(cyc), 128'(1));
        consume("zero clr", 0, fill_res(0));

        run_tile("stall", fill_in(4), fill_in(1), 1'b1, 2, 5, cyc);
        check("stall run cycles", 128'(cyc), 128'(9));
        consume("stall", 3, fill_res(12));

        for (int n = 1; n <= 13; n++) begin
            run_tile("wrap", fill_in(15), fill_in(15), (n == 1), 0, 0, cyc);
            if (n == 1) check("wrap run cycles", 128'(cyc), 128'(15));
            if (n == 4)       consume("wrap x4", 0, fill_res(2700));
            else if (n == 12) consume("wrap x12", 0, fill_res(8100));
            else if (n == 13) consume("wrap x13", 0, fill_res(583));
            else              consume("wrap step", 0, fill_res(675 * n));
        end

        bus.input_bin  = fill_in(15);
        bus.weight_bin = fill_in(15);
        bus.acc_clear  = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 128'({bus.busy, bus.out_valid}), 128'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        check("async reset flags", 128'({bus.out_valid, bus.busy}), 128'(2'b00));
        check("async reset acc", 128'(bus.accumulated_mult), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post-reset flags", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(3'b100));
        check("post-reset acc", 128'(bus.accumulated_mult), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
